// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute, evaluates branches,
// handles memory wait states with timeout, and traps on illegal encodings.
module multicycle_ctrl_fsm #(
    parameter int MEM_WAIT_EN = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int TRAP_EN     = 1,
    parameter int U_EN        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUOp,
    output logic [1:0] Fault,
    output logic [3:0] State
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRLINK = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    state_t        state_q, state_d, dec_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fault_q, fault_d, new_fault, dec_fault;
    logic          ready, timeout, cond, pc_upd, br;
    logic          memreq_s, irwrite_s, regwrite_s, memwrite_s;

    assign ready   = (MEM_WAIT_EN == 0) || MemReady;
    assign timeout = (MEM_WAIT_EN != 0) && (MEM_TIMEOUT != 0) && !MemReady
                     && (cnt_q == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = Zero;
            3'b001:  cond = !Zero;
            3'b100:  cond = Lt;
            3'b101:  cond = !Lt;
            3'b110:  cond = Ltu;
            3'b111:  cond = !Ltu;
            default: cond = 1'b0;
        endcase
    end

    // dec_fault != 0 marks an illegal encoding and its fault code
    always_comb begin
        dec_next  = S_FETCH;
        dec_fault = 2'b00;
        case (Op)
            7'b0000011,
            7'b0100011: dec_next = S_MEMADR;
            7'b0110011: dec_next = S_EXECR;
            7'b0010011: dec_next = S_EXECI;
            7'b1101111: dec_next = S_JAL;
            7'b1100111: begin
                if (funct3 == 3'b000) dec_next = S_JALR;
                else                  dec_fault = 2'b01;
            end
            7'b1100011: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_fault = 2'b11;
                else                                      dec_next  = S_BRANCH;
            end
            7'b0110111: begin
                if (U_EN != 0) dec_next = S_LUI;
                else           dec_fault = 2'b01;
            end
            7'b0010111: begin
                if (U_EN != 0) dec_next = S_AUIPC;
                else           dec_fault = 2'b01;
            end
            default: dec_fault = 2'b01;
        endcase
        if (dec_fault != 2'b00 && TRAP_EN != 0) dec_next = S_TRAP;
        if (TRAP_EN == 0) dec_fault = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        new_fault  = 2'b00;
        memreq_s   = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        pc_upd     = 1'b0;
        br         = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 3'b011;
        case (state_q)
            S_FETCH: begin
                memreq_s  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irwrite_s = ready;
                pc_upd    = ready;
                if (ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    new_fault = 2'b10;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                state_d   = dec_next;
                new_fault = dec_fault;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memreq_s = 1'b1;
                AdrSrc   = 1'b1;
                if (ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    new_fault = 2'b10;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                memreq_s   = 1'b1;
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    new_fault = 2'b10;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 3'b000;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b001;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALRLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_upd  = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALRLINK;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 3'b010;
                br      = 1'b1;
                state_d = S_FETCH;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // first fault is sticky; the wait counter restarts on entry to each wait state
    always_comb begin
        fault_d = (fault_q == 2'b00) ? new_fault : fault_q;
        cnt_d   = cnt_q;
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEMREAD
                                   || state_d == S_MEMWRITE)) begin
            cnt_d = '0;
        end else if (memreq_s && !MemReady && MEM_WAIT_EN != 0 && MEM_TIMEOUT != 0) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign MemReq   = rst & memreq_s;
    assign IRWrite  = rst & irwrite_s;
    assign RegWrite = rst & regwrite_s;
    assign MemWrite = rst & memwrite_s;
    assign PCWrite  = rst & (pc_upd | (br & cond));
    assign Fault    = fault_q;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios plus random
// instruction streams checked against an instruction-level sequence model.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] Op = 7'h13;
    logic [2:0] funct3 = 3'b000;
    logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemReq, IRWrite, RegWrite, MemWrite, AdrSrc, PCWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, Fault;
    logic [2:0] ALUOp;
    logic [3:0] State;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_ctrl_fsm #(
        .MEM_WAIT_EN(1),
        .MEM_TIMEOUT(4),
        .TRAP_EN(1),
        .U_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .MemReq(MemReq), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .PCWrite(PCWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .Fault(Fault), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // instruction kinds: 0 R, 1 I, 2 load, 3 store, 4 jal, 5 jalr, 6 branch, 7 lui, 8 auipc
    function automatic logic [6:0] op_of(input int k);
        case (k)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1101111;
            5: return 7'b1100111;
            6: return 7'b1100011;
            7: return 7'b0110111;
            default: return 7'b0010111;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        MemReady = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_state", State, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_memreq", MemReq, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_alusrcb", ALUSrcB, 2);
        chk("rst_resultsrc", ResultSrc, 2);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Runs one instruction from the start of FETCH; df/dm are not-ready cycles
    // in FETCH and in the data access.  Entry code = state + 16*MemReady.
    task automatic run_instr(input int k, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input int df, input int dm);
        int q[$];
        logic tk;
        Op     = op_of(k);
        funct3 = f3;
        Zero   = (a == b);
        Lt     = ($signed(a) < $signed(b));
        Ltu    = (a < b);
        tk     = taken_of(f3, a, b);
        for (int i = 0; i < df; i++) q.push_back(0);
        q.push_back(16);
        q.push_back(1 + 16 * int'($urandom_range(0, 1)));
        case (k)
            0: begin q.push_back(6); q.push_back(8); end
            1: begin q.push_back(7); q.push_back(8); end
            2: begin
                q.push_back(2);
                for (int i = 0; i < dm; i++) q.push_back(3);
                q.push_back(3 + 16);
                q.push_back(4);
            end
            3: begin
                q.push_back(2);
                for (int i = 0; i < dm; i++) q.push_back(5);
                q.push_back(5 + 16);
            end
            4: begin q.push_back(9); q.push_back(8); end
            5: begin q.push_back(10); q.push_back(11); q.push_back(8); end
            6: q.push_back(12);
            7: begin q.push_back(13); q.push_back(8); end
            default: begin q.push_back(14); q.push_back(8); end
        endcase
        foreach (q[i]) begin
            int s, r;
            s = q[i] % 16;
            r = q[i] / 16;
            // outside wait states MemReady is irrelevant, so toggle it freely
            if (s == 0 || s == 3 || s == 5) MemReady = r[0];
            else                            MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("state", State, s);
            chk("regwrite", RegWrite, (s == 4 || s == 8));
            chk("pcwrite", PCWrite, (s == 0) ? r[0] : (s == 9 || s == 11) ? 1'b1
                                    : (s == 12) ? tk : 1'b0);
            chk("memreq", MemReq, (s == 0 || s == 3 || s == 5));
            chk("memwrite", MemWrite, (s == 5));
            chk("irwrite", IRWrite, (s == 0 && r == 1));
            if (s == 3 || s == 5) chk("adrsrc", AdrSrc, 1);
            if (s == 4) chk("memwb_resultsrc", ResultSrc, 1);
            if (s == 13) begin
                chk("lui_srca", ALUSrcA, 3);
                chk("lui_srcb", ALUSrcB, 1);
            end
            if (s == 12) chk("branch_aluop", ALUOp, 2);
            @(posedge clk);
            #1;
        end
        chk("no_fault", Fault, 0);
    endtask

    task automatic to_trap(input logic [6:0] op, input logic [2:0] f3, input int fcode);
        Op = op;
        funct3 = f3;
        MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("trap_state", State, 15);
            chk("trap_fault", Fault, fcode);
            chk("trap_memreq", MemReq, 0);
            chk("trap_pcwrite", PCWrite, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k, df, dm;
        logic [2:0] f3;
        logic [2:0] br_f3 [6];
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        #3;
        do_reset();

        run_instr(0, 3'd0, 32'd1, 32'd2, 0, 0);
        run_instr(2, 3'd2, 32'd0, 32'd0, 0, 3);
        run_instr(6, 3'd6, 32'd5, 32'hFFFF_FFF0, 0, 0);
        run_instr(6, 3'd5, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_instr(5, 3'd0, 32'd0, 32'd0, 0, 0);
        run_instr(7, 3'd0, 32'd0, 32'd0, 0, 0);
        run_instr(3, 3'd2, 32'd0, 32'd0, 3, 3);

        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 8));
            f3 = 3'($urandom_range(0, 7));
            if (k == 5) f3 = 3'd0;
            if (k == 6) f3 = br_f3[$urandom_range(0, 5)];
            df = int'($urandom_range(0, 3));
            dm = int'($urandom_range(0, 3));
            run_instr(k, f3, $urandom, ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom,
                      df, dm);
        end

        // reset in the middle of a stalled store
        Op = 7'b0100011;
        MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MemReady = 1'b0;
        @(negedge clk);
        chk("sw_memwrite", MemWrite, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_memwrite", MemWrite, 0);
        chk("async_memreq", MemReq, 0);
        chk("async_state", State, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_instr(1, 3'd0, 32'd0, 32'd0, 1, 0);

        to_trap(7'b1100011, 3'b010, 3);
        do_reset();
        to_trap(7'h7F, 3'b000, 1);
        do_reset();

        // fetch never completes: trap after four wait cycles
        Op = 7'b0110011;
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_state", State, 0);
            chk("to_irwrite", IRWrite, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("to_trap_state", State, 15);
            chk("to_fault", Fault, 2);
            chk("to_irwrite_trap", IRWrite, 0);
            @(posedge clk); #1;
        end
        do_reset();
        run_instr(8, 3'd0, 32'd0, 32'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
